// File: rtl/move_command_generator.sv
// Push-button to move-command generator for the window-offset handler.
// Debounces four buttons and emits single-cycle, auto-repeating, accelerating moves.
module move_command_generator #(
    parameter int DEBOUNCE_CYCLES     = 250000,
    parameter int REPEAT_DELAY_FRAMES = 30,
    parameter int REPEAT_RATE_FRAMES  = 6,
    parameter int ACCEL_REPEATS       = 8,
    parameter int MAX_STEP            = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] buttonRaw,
    input  logic       frameTick,
    output logic [3:0] moveDirection,
    output logic [3:0] movemoveStep,
    output logic       busy
);
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int FMAX = (REPEAT_DELAY_FRAMES > REPEAT_RATE_FRAMES) ?
                          REPEAT_DELAY_FRAMES : REPEAT_RATE_FRAMES;
    localparam int FW = $clog2(FMAX + 1);
    localparam int RW = $clog2(ACCEL_REPEATS + 1);

    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [FW-1:0] DELAY_LAST = FW'(REPEAT_DELAY_FRAMES - 1);
    localparam logic [FW-1:0] RATE_LAST  = FW'(REPEAT_RATE_FRAMES - 1);
    localparam logic [RW-1:0] ACCEL_LAST = RW'(ACCEL_REPEATS - 1);
    localparam logic [3:0]    STEP_MAX   = 4'(MAX_STEP);

    typedef enum logic [1:0] {
        IDLE,
        HOLD_DELAY,
        REPEAT,
        WAIT_RELEASE
    } state_t;

    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    level;
    logic [3:0]    level_q;
    logic [DW-1:0] db_cnt [4];

    logic [3:0]    rise;
    logic [3:0]    first;
    logic          released;
    logic          frame_hit;

    state_t        state;
    logic [3:0]    dir;
    logic [FW-1:0] frame_cnt;
    logic [RW-1:0] rep_cnt;
    logic          bump;

    // Bring the asynchronous buttons into the clock domain.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= buttonRaw;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has disagreed for DEBOUNCE_CYCLES clocks.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            level   <= '0;
            level_q <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            level_q <= level;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Lowest set bit gives Up > Down > Left > Right priority.
    assign rise      = level & ~level_q;
    assign first     = rise & (~rise + 4'd1);
    assign released  = (level & dir) == 4'd0;
    assign frame_hit = frame_cnt == ((state == HOLD_DELAY) ? DELAY_LAST : RATE_LAST);

    // Command FSM: initial pulse, delayed auto-repeat, step acceleration.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            dir           <= '0;
            moveDirection <= '0;
            movemoveStep  <= 4'd1;
            busy          <= 1'b0;
            frame_cnt     <= '0;
            rep_cnt       <= '0;
            bump          <= 1'b0;
        end else begin
            moveDirection <= '0;
            bump          <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rise != 4'd0) begin
                        dir           <= first;
                        moveDirection <= first;
                        movemoveStep  <= 4'd1;
                        frame_cnt     <= '0;
                        rep_cnt       <= '0;
                        busy          <= 1'b1;
                        state         <= HOLD_DELAY;
                    end
                end
                HOLD_DELAY, REPEAT: begin
                    if (released) begin
                        dir          <= '0;
                        busy         <= 1'b0;
                        movemoveStep <= 4'd1;
                        state        <= (level == 4'd0) ? IDLE : WAIT_RELEASE;
                    end else begin
                        if (bump && movemoveStep < STEP_MAX) begin
                            movemoveStep <= movemoveStep + 4'd1;
                        end
                        if (frameTick) begin
                            if (frame_hit) begin
                                frame_cnt     <= '0;
                                moveDirection <= dir;
                                state         <= REPEAT;
                                if (rep_cnt == ACCEL_LAST) begin
                                    rep_cnt <= '0;
                                    bump    <= 1'b1;
                                end else begin
                                    rep_cnt <= rep_cnt + 1'b1;
                                end
                            end else begin
                                frame_cnt <= frame_cnt + 1'b1;
                            end
                        end
                    end
                end
                WAIT_RELEASE: begin
                    if (level == 4'd0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/move_command_generator.md
Name: move_command_generator

Overview:
- Initiator side of the window-offset interface: converts four raw, bouncing push-buttons into move commands (moveDirection, movemoveStep) for the drawable-region offset handler.
- The offset handler moves the region on every clock where a direction bit is high, so every command is a single-cycle pulse.
- Held buttons auto-repeat, paced by the frame tick, and accelerate by raising the step size.

Parameters:
- DEBOUNCE_CYCLES, 250000, clocks a synchronised button level must be stable before it is accepted.
- REPEAT_DELAY_FRAMES, 30, frame ticks between the initial pulse and the first repeat pulse.
- REPEAT_RATE_FRAMES, 6, frame ticks between subsequent repeat pulses.
- ACCEL_REPEATS, 8, repeat pulses per step increment.
- MAX_STEP, 4, saturation value of movemoveStep (1..15).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- buttonRaw  in  4  raw buttons {Right, Left, Down, Up}, asynchronous, active-high.
- frameTick  in  1  one-cycle strobe, once per frame (vsync-derived).
- moveDirection  out  4  one-hot single-cycle move pulse {Right, Left, Down, Up}.
- movemoveStep  out  4  step multiplier valid whenever moveDirection != 0.
- busy  out  1  high while a direction is latched (HOLD_DELAY or REPEAT).

Behaviour:
- Reset (reset=0, asynchronous):
  - moveDirection=0, movemoveStep=1, busy=0.
  - Synchronisers, debounced levels and counters are 0; FSM is IDLE.
  - Deassertion is sampled synchronously.
  - A button held through reset is treated as a new press after debounce.
- Input conditioning:
  - Each buttonRaw bit passes through a 2-flop synchroniser, then an independent debouncer.
  - The debounce counter clears whenever the synchronised value equals the debounced level.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level takes the synchronised value and the counter clears.
- Latency: buttonRaw held high from clock edge k gives a moveDirection pulse at edge k+DEBOUNCE_CYCLES+3.
- Rise detect: the debounced level is 1 this cycle and was 0 last cycle.
- FSM states: IDLE, HOLD_DELAY, REPEAT, WAIT_RELEASE.
- IDLE:
  - On any rise: latch the lowest-index rising bit (priority Up>Down>Left>Right).
  - Pulse that bit on moveDirection for exactly one cycle, with movemoveStep=1.
  - Clear frame and repeat counters; go to HOLD_DELAY.
- HOLD_DELAY:
  - Count frameTick.
  - On the REPEAT_DELAY_FRAMES-th tick: issue a pulse, increment the repeat counter, clear the frame counter, go to REPEAT.
- REPEAT: on every REPEAT_RATE_FRAMES-th tick, issue a pulse and increment the repeat counter.
- Acceleration:
  - When the repeat counter reaches ACCEL_REPEATS, it clears and movemoveStep increments, saturating at MAX_STEP.
  - The step change takes effect the cycle after the pulse. movemoveStep never changes while moveDirection != 0.
- Release:
  - If the latched button's debounced level falls in HOLD_DELAY or REPEAT: go to IDLE if all debounced levels are 0, else to WAIT_RELEASE.
  - movemoveStep returns to 1 on the next cycle.
  - If release coincides with a qualifying frameTick, release wins and no pulse is issued.
- Other buttons pressed while a direction is latched are ignored and produce no pulse.
- WAIT_RELEASE:
  - No pulses.
  - Go to IDLE in the cycle after all debounced levels are 0.
  - A button still held does not retrigger.
- Output invariants:
  - moveDirection is registered, at most one bit high, and never high two consecutive cycles.
  - busy=1 exactly in HOLD_DELAY and REPEAT.
- Widths:
  - Debounce counter: clog2(DEBOUNCE_CYCLES) bits.
  - Frame counter: clog2(max(REPEAT_DELAY_FRAMES, REPEAT_RATE_FRAMES)+1) bits.
  - All counters saturate or clear, never wrap silently.
- frameTick is ignored in IDLE and WAIT_RELEASE.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY_FRAMES=3, REPEAT_RATE_FRAMES=2, ACCEL_REPEATS=2, MAX_STEP=3; frameTick every 10 clocks.
- Single press: buttonRaw=4'b0001 from edge 10, released after 15 clocks -> moveDirection=4'b0001 only at edge 17, step=1; no repeat; busy falls after debounced release.
- Bounce: buttonRaw[1] toggles every 2 clocks for 20 clocks, then holds 1 -> no pulse during bouncing; one pulse 4'b0010 exactly 7 clocks after the final rise.
- Hold and accelerate: hold Right for 200 clocks -> first pulse 4'b1000 (step 1); repeat pulses on the 3rd tick, then every 2nd tick; movemoveStep reads 1,1,2,2,3,3,3.
- Priority and lockout: Up and Left rise together -> only 4'b0001 pulses. Release Up while Left is held -> WAIT_RELEASE, no Left pulse. Release all, press Left -> 4'b0100.
- Release vs repeat: release the held button so its debounced fall coincides with a repeat-qualifying frameTick -> no pulse; step returns to 1.
- Async reset: assert reset mid-REPEAT (step=2) without a clock edge -> outputs immediately 0/1/0. Deassert with the button still held -> a fresh initial pulse after DEBOUNCE_CYCLES+3 clocks.
